// File: rtl/dot_matrix_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dot_matrix_decoder                                         |
// | Description : Samples an 8x8 row-scanned dot-matrix display, rebuilds    |
// |               each frame and decodes it to a traffic-light colour.       |
// |               Flags scan-order errors and reports loss of scan.          |
// |               Optional macro DOT_DECODE_CONFIRM_EN: the colour output     |
// |               only changes after two consecutive frames agree.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dot_matrix_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       clk_div_10000hz,
  input  logic       rst_n,
  input  logic [7:0] dot_row,
  input  logic [7:0] dot_col,
  output logic [1:0] state,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       signal_lost
);

  localparam logic [1:0]  c_red     = 2'b00;
  localparam logic [1:0]  c_yellow  = 2'b01;
  localparam logic [1:0]  c_green   = 2'b10;
  localparam logic [1:0]  c_none    = 2'b11;
  localparam logic [7:0]  c_timeout = 8'(TIMEOUT_CYCLES);

  // Glyphs packed row 0 in the top byte down to row 7 in the bottom byte.
  localparam logic [63:0] c_glyph_red    = 64'h18183C3C5A181824;
  localparam logic [63:0] c_glyph_yellow = 64'h00243CBDFF3C3C00;
  localparam logic [63:0] c_glyph_green  = 64'h0C0C197E98182848;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } fsm_t;

  fsm_t       fsm_q, fsm_d, fsm_cur;
  logic [2:0] exp_q, exp_d;
  // Rows 0..6 are buffered; row 7 is compared straight from the input.
  logic [7:0] buf_q [7];
  logic [7:0] buf_d [7];
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic       frame_valid_q, frame_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       signal_lost_q, signal_lost_d;
`ifdef DOT_DECODE_CONFIRM_EN
  logic [1:0] hist_q, hist_d;
`endif

  logic       row_legal;
  logic       row_blank;
  logic [2:0] row_idx;
  logic       timeout_hit;
  logic [63:0] frame_bits;
  logic [1:0] frame_dec;

  // Classify the sampled row select as a single row code, blank or illegal.
  always_comb begin
    row_legal = 1'b0;
    row_idx   = 3'd0;
    row_blank = (dot_row == 8'hFF);
    for (int r = 0; r < 8; r++) begin
      if (dot_row == ~(8'h80 >> r)) begin
        row_legal = 1'b1;
        row_idx   = 3'(r);
      end
    end
  end

  // Match the buffered rows plus the live row 7 against the glyph tables.
  always_comb begin
    frame_bits = {buf_q[0], buf_q[1], buf_q[2], buf_q[3],
                  buf_q[4], buf_q[5], buf_q[6], dot_col};
    if (frame_bits == c_glyph_red) begin
      frame_dec = c_red;
    end else if (frame_bits == c_glyph_yellow) begin
      frame_dec = c_yellow;
    end else if (frame_bits == c_glyph_green) begin
      frame_dec = c_green;
    end else begin
      frame_dec = c_none;
    end
  end

  // Next-state logic for the scan FSM, frame buffer, timeout and outputs.
  always_comb begin
    fsm_d         = fsm_q;
    exp_d         = exp_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    state_d       = state_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    signal_lost_d = signal_lost_q;
`ifdef DOT_DECODE_CONFIRM_EN
    hist_d        = hist_q;
`endif

    // A timeout forces HUNT, but the current sample is still evaluated from
    // HUNT so a row 0 arriving on that edge is not lost.
    timeout_hit = (cnt_q == c_timeout);
    fsm_cur     = timeout_hit ? HUNT : fsm_q;
    if (timeout_hit) begin
      state_d       = c_none;
      signal_lost_d = 1'b1;
      fsm_d         = HUNT;
      exp_d         = 3'd0;
    end

    // Saturating count of consecutive non-row samples.
    if (row_legal) begin
      cnt_d = 8'd0;
    end else if (cnt_q != c_timeout) begin
      cnt_d = cnt_q + 8'd1;
    end

    if (!row_legal && !row_blank) begin
      frame_err_d = 1'b1;
      fsm_d       = HUNT;
      exp_d       = 3'd0;
    end else if (row_legal) begin
      if (fsm_cur == HUNT) begin
        if (row_idx == 3'd0) begin
          buf_d[0] = dot_col;
          exp_d    = 3'd1;
          fsm_d    = CAPTURE;
        end
      end else if (row_idx != exp_q) begin
        // Out-of-order row: a fresh row 0 restarts, anything else drops out.
        frame_err_d = 1'b1;
        if (row_idx == 3'd0) begin
          buf_d[0] = dot_col;
          exp_d    = 3'd1;
          fsm_d    = CAPTURE;
        end else begin
          fsm_d = HUNT;
          exp_d = 3'd0;
        end
      end else if (row_idx == 3'd7) begin
        frame_valid_d = 1'b1;
        signal_lost_d = 1'b0;
        fsm_d         = HUNT;
        exp_d         = 3'd0;
`ifdef DOT_DECODE_CONFIRM_EN
        if (frame_dec == hist_q) begin
          state_d = frame_dec;
        end
        hist_d = frame_dec;
`else
        state_d = frame_dec;
`endif
      end else begin
        buf_d[exp_q] = dot_col;
        exp_d        = exp_q + 3'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_div_10000hz or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= HUNT;
      exp_q         <= 3'd0;
      for (int i = 0; i < 7; i++) begin
        buf_q[i] <= 8'h00;
      end
      cnt_q         <= 8'd0;
      state_q       <= c_none;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      signal_lost_q <= 1'b0;
`ifdef DOT_DECODE_CONFIRM_EN
      hist_q        <= c_none;
`endif
    end else begin
      fsm_q         <= fsm_d;
      exp_q         <= exp_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      signal_lost_q <= signal_lost_d;
`ifdef DOT_DECODE_CONFIRM_EN
      hist_q        <= hist_d;
`endif
    end
  end

  assign state       = state_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign signal_lost = signal_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dot_matrix_decoder                                      |
// | Description : Self-checking bench for dot_matrix_decoder (default        |
// |               TIMEOUT_CYCLES); frame colour is checked with or without   |
// |               DOT_DECODE_CONFIRM_EN via build-dependent expectations.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_dot_matrix_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dot_row;
  logic [7:0] dot_col;
  logic [1:0] state;
  logic       frame_valid;
  logic       frame_err;
  logic       signal_lost;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic [1:0] st;
    logic       fv;
    logic       fe;
    logic       sl;
    logic       chk_st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  localparam logic [63:0] G_RED    = 64'h18183C3C5A181824;
  localparam logic [63:0] G_YELLOW = 64'h00243CBDFF3C3C00;
  localparam logic [63:0] G_GREEN  = 64'h0C0C197E98182848;
  localparam logic [63:0] G_GBAD   = 64'h0C0C197F98182848;

`ifdef DOT_DECODE_CONFIRM_EN
  localparam logic       CHK_ST = 1'b0;
  localparam logic [1:0] CF1 = 2'b11;
  localparam logic [1:0] CF2 = 2'b00;
  localparam logic [1:0] CF3 = 2'b00;
  localparam logic [1:0] CF4 = 2'b10;
`else
  localparam logic       CHK_ST = 1'b1;
  localparam logic [1:0] CF1 = 2'b00;
  localparam logic [1:0] CF2 = 2'b00;
  localparam logic [1:0] CF3 = 2'b10;
  localparam logic [1:0] CF4 = 2'b10;
`endif

  always #5 clk = ~clk;

  dot_matrix_decoder #(.TIMEOUT_CYCLES(32)) dut (
    .clk_div_10000hz (clk),
    .rst_n           (rst_n),
    .dot_row         (dot_row),
    .dot_col         (dot_col),
    .state           (state),
    .frame_valid     (frame_valid),
    .frame_err       (frame_err),
    .signal_lost     (signal_lost)
  );

  function automatic logic [7:0] row_code(input int r);
    logic [7:0] v;
    v        = 8'hFF;
    v[7 - r] = 1'b0;
    return v;
  endfunction

  function automatic void add(input logic [7:0] row, input logic [7:0] col,
                              input logic [1:0] st, input logic fv,
                              input logic fe, input logic sl, input logic chk);
    vec_t v;
    v.row = row; v.col = col; v.st = st;
    v.fv = fv; v.fe = fe; v.sl = sl; v.chk_st = chk;
    vecs.push_back(v);
  endfunction

  // Rows first..last of glyph g; the row 7 entry carries the decode result.
  function automatic void add_rows(input logic [63:0] g, input int first,
                                   input int last, input logic [1:0] st_before,
                                   input logic [1:0] st_after, input logic sl_before,
                                   input logic chk);
    for (int r = first; r <= last; r++) begin
      if (r < 7) add(row_code(r), g[63 - 8*r -: 8], st_before, 1'b0, 1'b0, sl_before, chk);
      else       add(row_code(7), g[7:0], st_after, 1'b1, 1'b0, 1'b0, chk);
    end
  endfunction

  task automatic check_val(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic run_vecs();
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      dot_row = vecs[i].row;
      dot_col = vecs[i].col;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({frame_valid, frame_err, signal_lost} !== {e.fv, e.fe, e.sl} ||
          (e.chk_st && state !== e.st)) begin
        errors++;
        $display("FAIL vec %0d row=%h col=%h: got st=%b fv=%b fe=%b sl=%b, expected st=%b fv=%b fe=%b sl=%b",
                 i, e.row, e.col, state, frame_valid, frame_err, signal_lost,
                 e.st, e.fv, e.fe, e.sl);
      end
    end
    vecs.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    dot_row = 8'hFF;
    dot_col = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", {2'b00, state}, 4'b0011);
    check_val("reset_frame_valid", {3'b000, frame_valid}, 4'b0000);
    check_val("reset_frame_err", {3'b000, frame_err}, 4'b0000);
    check_val("reset_signal_lost", {3'b000, signal_lost}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // RED, then back-to-back GREEN with a corrupted row 3 -> NONE.
    add_rows(G_RED, 0, 7, 2'b11, 2'b00, 1'b0, CHK_ST);
    add_rows(G_GBAD, 0, 7, 2'b00, 2'b11, 1'b0, CHK_ST);
    // Rows 0,1,2 then row 5 -> scan-order error.
    add_rows(G_YELLOW, 0, 2, 2'b11, 2'b11, 1'b0, CHK_ST);
    add(row_code(5), 8'h3C, 2'b11, 1'b0, 1'b1, 1'b0, CHK_ST);
    add_rows(G_YELLOW, 0, 7, 2'b11, 2'b01, 1'b0, CHK_ST);
    add_rows(G_GREEN, 0, 7, 2'b01, 2'b10, 1'b0, CHK_ST);
    // Illegal two-hot row code mid-capture; following rows are ignored.
    add_rows(G_RED, 0, 1, 2'b10, 2'b10, 1'b0, CHK_ST);
    add(8'b00111111, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0, CHK_ST);
    add_rows(G_RED, 2, 6, 2'b10, 2'b10, 1'b0, CHK_ST);
    add(row_code(7), 8'h24, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add(8'hFF, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add(8'hFF, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    // Blank samples inside a capture are transparent.
    add_rows(G_RED, 0, 1, 2'b10, 2'b10, 1'b0, CHK_ST);
    add(8'hFF, 8'hAA, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add_rows(G_RED, 2, 2, 2'b10, 2'b10, 1'b0, CHK_ST);
    add(8'hFF, 8'h55, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add_rows(G_RED, 3, 7, 2'b10, 2'b00, 1'b0, CHK_ST);
    // Row 7 arriving early: error wins, no decode.
    add_rows(G_RED, 0, 5, 2'b00, 2'b00, 1'b0, CHK_ST);
    add(row_code(7), 8'h24, 2'b00, 1'b0, 1'b1, 1'b0, CHK_ST);
    // Row 0 mid-capture restarts the frame.
    add_rows(G_GREEN, 0, 2, 2'b00, 2'b00, 1'b0, CHK_ST);
    add(row_code(0), 8'h0C, 2'b00, 1'b0, 1'b1, 1'b0, CHK_ST);
    add_rows(G_GREEN, 1, 7, 2'b00, 2'b10, 1'b0, CHK_ST);
    // HUNT ignores rows other than 0.
    add(row_code(3), 8'hFF, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add(row_code(6), 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    // 32 blanks reach the limit; the next edge declares loss.
    for (int i = 0; i < 32; i++) add(8'hFF, 8'h00, 2'b10, 1'b0, 1'b0, 1'b0, CHK_ST);
    add(8'hFF, 8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    add_rows(G_RED, 0, 7, 2'b11, 2'b00, 1'b1, CHK_ST);
    run_vecs();

    // Reset asserted after the row 4 sample discards the partial frame.
    add_rows(G_RED, 0, 4, 2'b00, 2'b00, 1'b0, CHK_ST);
    run_vecs();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_state", {2'b00, state}, 4'b0011);
    check_val("async_reset_flags", {1'b0, frame_valid, frame_err, signal_lost}, 4'b0000);
    dot_row = row_code(0);
    dot_col = 8'h18;
    repeat (2) @(posedge clk);
    #1;
    check_val("held_reset_state", {2'b00, state}, 4'b0011);
    check_val("held_reset_flags", {1'b0, frame_valid, frame_err, signal_lost}, 4'b0000);
    @(negedge clk);
    dot_row = 8'hFF;
    rst_n   = 1'b1;
    add_rows(G_RED, 5, 6, 2'b11, 2'b11, 1'b0, 1'b1);
    add(row_code(7), 8'h24, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    // RED, RED, GREEN, GREEN: colour depends on confirm build.
    add_rows(G_RED, 0, 7, 2'b11, CF1, 1'b0, 1'b1);
    add_rows(G_RED, 0, 7, CF1, CF2, 1'b0, 1'b1);
    add_rows(G_GREEN, 0, 7, CF2, CF3, 1'b0, 1'b1);
    add_rows(G_GREEN, 0, 7, CF3, CF4, 1'b0, 1'b1);
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
